regwrite_scheduler: RTL and testbench
=====================================

# regwrite_scheduler

Shares the register file's single write port (we3/a3/wd3) between the in-order writeback stage and an out-of-band long-latency unit (LU: divider, multi-cycle load) through a small result FIFO. It keeps a per-register busy scoreboard so decode stalls on operands or destinations owned by an in-flight LU operation. It sits beside the decode-stage register file. It drives that file's write port and the decode stall.

## Interface
- XLEN, 32, datapath width
- FIFO_DEPTH, 2, LU result FIFO entries (≥1)
- STARVE_LIMIT, 4, cycles the FIFO head may wait before writeback is held (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- RegWriteW  in  1  writeback stage write request
- RdW  in  5  writeback destination
- ResultW  in  XLEN  writeback data
- HoldW  out  1  writeback must re-present the same write next cycle
- issue_valid  in  1  decode hands an LU op downstream this cycle
- issue_rd  in  5  destination of that LU op
- lu_valid  in  1  LU result available
- lu_rd  in  5  LU result destination
- lu_data  in  XLEN  LU result value
- lu_ready  out  1  FIFO accepts LU result this cycle
- Rs1D, Rs2D, RdD  in  5 each  decode operand/destination addresses
- StallD  out  1  decode hazard on a busy register
- we3  out  1  register file write enable
- a3  out  5  register file write address
- wd3  out  XLEN  register file write data
- busy  out  32  scoreboard bits (bit 0 always 0)

## Operation
- Write-port grant is combinational and evaluated each cycle:
  - If HoldW=0 and RegWriteW=1 and RdW≠0, writeback wins: we3=1, a3=RdW, wd3=ResultW.
  - Otherwise, if the FIFO is non-empty, the head wins: we3 = (head.rd≠0), a3=head.rd, wd3=head.data. The head pops at the edge.
  - Otherwise we3=0. a3 and wd3 are don't-care but are driven as 0.
- Writeback requests with RdW=0 count as no request.
- FIFO:
  - Pushes {lu_rd, lu_data} when lu_valid & lu_ready.
  - lu_ready = reset deasserted & (not full). Pop-frees-slot does not raise lu_ready in the same cycle.
  - Push and pop in the same cycle are legal. Ordering is strict FIFO.
- Starvation counter (width ceil(log2(STARVE_LIMIT+1))):
  - Increments when the FIFO is non-empty and the head did not pop.
  - Clears when the head pops or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - HoldW = (cnt == STARVE_LIMIT), driven from the register. In a HoldW cycle the writeback input is ignored, the head pops and the counter clears. The pipeline must freeze its W register so the ignored write repeats.
- Scoreboard:
  - busy[issue_rd] sets on issue_valid when issue_rd≠0.
  - busy[a3] clears when the FIFO head is written.
  - A set and a clear of the same bit in one cycle resolve to set.
  - Writeback writes never touch busy.
- StallD = busy[Rs1D] | busy[Rs2D] | busy[RdD], with index 0 masked.
  - RdD is included to block WAW ordering violations.
  - Decode must not assert issue_valid while StallD=1.
- LU results for x0 pop without writing and clear nothing.

## Timing
- Reset values: FIFO empty, cnt=0, busy=0.
  - HoldW=0, StallD=0, lu_ready=0 while reset is low.
  - we3 follows the writeback inputs only (there is no FIFO traffic during reset).
- Writeback path latency: 0. The write lands at the same edge, as without the block.
- LU path latency: at least 1 cycle from lu_valid&lu_ready to we3 (no bypass). At most STARVE_LIMIT+1 cycles after the entry reaches the head.
- A busy bit falls at the edge where the regfile write occurs. StallD drops in the following cycle, when the regfile read returns the new value.
- Full FIFO: lu_ready=0. The LU must hold lu_valid/lu_rd/lu_data stable until accepted.
- Asynchronous reset mid-operation discards FIFO contents and busy bits. The outputs above take their reset values immediately.

## Test plan
- FIFO_DEPTH=2. Issue x5; no writeback traffic; lu result (x5, 0xDEAD_BEEF) -> one cycle later we3=1, a3=5, wd3=0xDEADBEEF. busy[5] is 1 from the issue edge until the write edge. StallD=1 for Rs1D=5 until the write edge, then 0.
- Writeback to x7 in the same cycle the FIFO head (x5) is ready -> writeback written first. Head written next idle cycle. cnt=1 meanwhile.
- Continuous RegWriteW to x3 with head x9 pending, STARVE_LIMIT=4 -> HoldW=1 on the 5th cycle. That cycle writes x9. The x3 write repeats the next cycle. No write is lost.
- Three back-to-back lu_valid with writeback busy every cycle -> lu_ready=0 on the third. The result is accepted once a head drains. All three are written in order.
- issue_valid rd=8 in the same cycle the FIFO head writes x8 -> busy[8] remains 1. lu result x0 -> we3=0, no busy change. Reset pulse with 2 FIFO entries -> empty, busy=0, we3 quiet.

Source files
------------

// File: rtl/regwrite_scheduler.sv
// Purpose: shares the regfile write port between writeback and a long-latency unit result FIFO, with a busy scoreboard.
// Latency: writeback 0 cycles (same edge); LU result >=1 cycle, at most STARVE_LIMIT+1 cycles after reaching the FIFO head.
// Backpressure: lu_ready drops when the FIFO is full; HoldW asks writeback to repeat its write when the FIFO head starves.
//
// Ports:
//   clk, reset (async, active-low)
//   RegWriteW/RdW/ResultW -> writeback request;  HoldW -> writeback must re-present next cycle
//   issue_valid/issue_rd  -> marks an LU destination busy
//   lu_valid/lu_rd/lu_data, lu_ready -> LU result push into the FIFO
//   Rs1D/Rs2D/RdD -> decode addresses;  StallD -> decode hazard
//   we3/a3/wd3 -> regfile write port;  busy -> scoreboard bits (bit 0 always 0)
module regwrite_scheduler #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            HoldW,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            StallD,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic [31:0]     busy
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  // FIFO storage and pointers
  logic [4:0]      ent_rd_q   [FIFO_DEPTH];
  logic [4:0]      ent_rd_d   [FIFO_DEPTH];
  logic [XLEN-1:0] ent_data_q [FIFO_DEPTH];
  logic [XLEN-1:0] ent_data_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  // Starvation counter and scoreboard
  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     busy_q, busy_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            wb_req;
  logic            wb_win;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
  assign head_rd    = ent_rd_q[rd_ptr_q];
  assign head_data  = ent_data_q[rd_ptr_q];

  // Registered so the hold decision never depends on this cycle's writeback request.
  assign HoldW    = (starve_q == SW'(STARVE_LIMIT));
  // Based on registered occupancy only: a pop in this cycle does not open a slot until the next one.
  assign lu_ready = reset & ~fifo_full;
  assign push     = lu_valid & lu_ready;
  assign busy     = busy_q;

  // Write-port grant: writeback first unless the head has starved long enough.
  always_comb begin
    wb_req = RegWriteW & (RdW != 5'd0);
    wb_win = wb_req & ~HoldW;
    pop    = ~wb_win & ~fifo_empty;
    we3    = 1'b0;
    a3     = 5'd0;
    wd3    = '0;
    if (wb_win) begin
      we3 = 1'b1;
      a3  = RdW;
      wd3 = ResultW;
    end else if (pop) begin
      // x0 results still pop, but never write.
      we3 = (head_rd != 5'd0);
      a3  = head_rd;
      wd3 = head_data;
    end
  end

  // Index 0 is masked so a stray x0 reference can never stall decode.
  always_comb begin
    StallD = ((Rs1D != 5'd0) & busy_q[Rs1D]) |
             ((Rs2D != 5'd0) & busy_q[Rs2D]) |
             ((RdD  != 5'd0) & busy_q[RdD]);
  end

  // FIFO next state
  always_comb begin
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      ent_rd_d[wr_ptr_q]   = lu_rd;
      ent_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: counts cycles the current head has been passed over.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Scoreboard: set is applied after clear so a same-cycle issue of the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head_rd != 5'd0)) begin
      busy_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_rd_q[i]   <= 5'd0;
        ent_data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_regwrite_scheduler.sv
// Purpose: directed scenarios plus randomized traffic against a queue-based reference of the write-port scheduler.
// Latency: inputs driven 1ns after the rising edge, outputs compared on the falling edge.
// Backpressure: the LU source holds its result until the reference says it was accepted.
module tb_regwrite_scheduler;

  localparam int XLEN         = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            HoldW;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            StallD;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     busy;

  int checks   = 0;
  int failures = 0;

  // Reference state: pending LU results in arrival order, cycles the head has waited, busy registers.
  ent_t        mq[$];
  int          wcnt;
  logic [31:0] mbusy;
  logic        m_acc;

  always #5 clk = ~clk;

  regwrite_scheduler #(
    .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(rst_n),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .HoldW(HoldW),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .StallD(StallD),
    .we3(we3), .a3(a3), .wd3(wd3), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_stall();
    return ((Rs1D != 0) && mbusy[Rs1D]) || ((Rs2D != 0) && mbusy[Rs2D]) ||
           ((RdD != 0) && mbusy[RdD]);
  endfunction

  function automatic logic model_hold();
    return (wcnt == STARVE_LIMIT);
  endfunction

  task automatic model_reset();
    mq.delete();
    wcnt  = 0;
    mbusy = '0;
    m_acc = 1'b0;
  endtask

  // One clock cycle: predict outputs from the reference, compare on the falling edge, advance the reference.
  task automatic step();
    logic        hold, wbwin, pop, ew, rdy, es;
    logic [4:0]  ea;
    logic [31:0] ed;
    ent_t        h;
    hold  = model_hold();
    wbwin = !hold && RegWriteW && (RdW != 0);
    pop   = !wbwin && (mq.size() != 0);
    ew = 1'b0; ea = '0; ed = '0;
    if (wbwin) begin
      ew = 1'b1; ea = RdW; ed = ResultW;
    end else if (pop) begin
      ew = (mq[0].rd != 0); ea = mq[0].rd; ed = mq[0].data;
    end
    rdy = rst_n && (mq.size() < FIFO_DEPTH);
    es  = model_stall();
    @(negedge clk);
    chk("we3", we3, ew);
    chk("a3", a3, ea);
    chk("wd3", wd3, ed);
    chk("HoldW", HoldW, hold);
    chk("lu_ready", lu_ready, rdy);
    chk("StallD", StallD, es);
    chk("busy", busy, mbusy);
    if (pop || mq.size() == 0) wcnt = 0;
    else if (wcnt < STARVE_LIMIT) wcnt++;
    if (pop) begin
      h = mq.pop_front();
      if (h.rd != 0) mbusy[h.rd] = 1'b0;
    end
    if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    m_acc = lu_valid && rdy;
    if (m_acc) mq.push_back('{lu_rd, lu_data});
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic got;
    logic lu_pend;
    rst_n = 1'b0;
    RegWriteW = 0; RdW = 0; ResultW = 0;
    issue_valid = 0; issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
    model_reset();
    #2;
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_HoldW", HoldW, 0);
    chk("rst_StallD", StallD, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we3", we3, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Issue x5, its LU result arrives, lands one cycle later.
    issue_valid = 1; issue_rd = 5; Rs1D = 5;
    settle(); chk("t1_stall_pre", StallD, 0);
    step();
    issue_valid = 0; lu_valid = 1; lu_rd = 5; lu_data = 32'hDEAD_BEEF;
    settle(); chk("t1_busy5", busy[5], 1); chk("t1_stall", StallD, 1); chk("t1_nowrite", we3, 0);
    step();
    lu_valid = 0;
    settle(); chk("t1_we3", we3, 1); chk("t1_a3", a3, 5); chk("t1_wd3", wd3, 32'hDEAD_BEEF);
    chk("t1_stall_wr", StallD, 1);
    step();
    settle(); chk("t1_stall_post", StallD, 0); chk("t1_busy5_clr", busy[5], 0);
    step();
    Rs1D = 0;

    // Writeback beats a waiting head; head written next idle cycle.
    lu_valid = 1; lu_rd = 5; lu_data = 32'h0000_1234;
    step();
    lu_valid = 0; RegWriteW = 1; RdW = 7; ResultW = 32'h77;
    settle(); chk("t2_wb_a3", a3, 7); chk("t2_wb_wd3", wd3, 32'h77);
    step();
    RegWriteW = 0;
    settle(); chk("t2_head_we3", we3, 1); chk("t2_head_a3", a3, 5); chk("t2_head_wd3", wd3, 32'h1234);
    step();

    // Starvation: continuous writeback to x3 with x9 waiting.
    lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
    step();
    lu_valid = 0; RegWriteW = 1; RdW = 3; ResultW = 32'h33;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      settle(); chk("t3_nohold", HoldW, 0); chk("t3_wb_a3", a3, 3);
      step();
    end
    settle(); chk("t3_hold", HoldW, 1); chk("t3_head_a3", a3, 9); chk("t3_head_wd3", wd3, 32'h99);
    step();
    settle(); chk("t3_release", HoldW, 0); chk("t3_repeat_a3", a3, 3); chk("t3_repeat_we3", we3, 1);
    step();

    // Three back-to-back LU results while writeback is busy every cycle.
    for (int k = 0; k < 3; k++) begin
      lu_valid = 1; lu_rd = 5'(10 + k); lu_data = 32'hA0 + k;
      got = 1'b0;
      if (k == 2) begin
        settle(); chk("t4_full", lu_ready, 0);
      end
      for (int n = 0; n < 20 && !got; n++) begin
        step();
        got = m_acc;
      end
      chk("t4_accepted", got, 1);
    end
    lu_valid = 0;
    for (int n = 0; n < 12; n++) step();
    RegWriteW = 0;
    for (int n = 0; n < 4; n++) step();
    chk("t4_drained", mq.size(), 0);

    // Issue x8 in the same cycle the head writes x8: bit must stay set.
    issue_valid = 1; issue_rd = 8;
    step();
    issue_valid = 0; lu_valid = 1; lu_rd = 8; lu_data = 32'h88;
    step();
    lu_valid = 0; issue_valid = 1; issue_rd = 8;
    settle(); chk("t5_head_a3", a3, 8);
    step();
    issue_valid = 0;
    settle(); chk("t5_busy8", busy[8], 1);
    lu_valid = 1; lu_rd = 0; lu_data = 32'hFFFF;
    step();
    lu_valid = 0;
    settle(); chk("t5_x0_we3", we3, 0); chk("t5_x0_busy", busy, 32'h0000_0100);
    step();

    // Reset pulse with two entries queued.
    RegWriteW = 1; RdW = 4; ResultW = 32'h44; Rs1D = 8;
    lu_valid = 1; lu_rd = 13; lu_data = 32'hD;
    step();
    lu_rd = 14; lu_data = 32'hE;
    step();
    lu_valid = 0;
    chk("t6_two_queued", mq.size(), 2);
    #2; rst_n = 1'b0; #1;
    chk("t6_lu_ready", lu_ready, 0);
    chk("t6_HoldW", HoldW, 0);
    chk("t6_StallD", StallD, 0);
    chk("t6_busy", busy, 0);
    chk("t6_we3_wb", we3, 1);
    chk("t6_a3_wb", a3, 4);
    RegWriteW = 0;
    #1; chk("t6_we3_quiet", we3, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    Rs1D = 0;
    step();
    step();

    // Randomized traffic.
    lu_pend = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!model_hold()) begin
        RegWriteW = ($urandom_range(0, 2) != 0);
        RdW       = 5'($urandom);
        ResultW   = $urandom;
      end
      if (!lu_pend) begin
        lu_valid = ($urandom_range(0, 1) == 1);
        lu_rd    = 5'($urandom_range(0, 15));
        lu_data  = $urandom;
      end
      Rs1D = 5'($urandom_range(0, 15));
      Rs2D = 5'($urandom_range(0, 15));
      RdD  = 5'($urandom_range(0, 15));
      if (!model_stall() && $urandom_range(0, 2) == 0) begin
        issue_valid = 1; issue_rd = RdD;
      end else begin
        issue_valid = 0; issue_rd = 5'($urandom);
      end
      step();
      lu_pend = lu_valid && !m_acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
